// File: rtl/ans_symbol_encoder_if.sv
// ans_symbol_encoder_if: table load, symbol in, byte out and status.
// master = symbol source / byte sink, slave = encoder.
interface ans_symbol_encoder_if #(
  parameter int STATE_WIDTH  = 32,
  parameter int PROB_WIDTH   = 8,
  parameter int SYMBOL_WIDTH = 4
);
  logic                    table_write;
  logic [SYMBOL_WIDTH-1:0] table_addr;
  logic [PROB_WIDTH-1:0]   table_freq;
  logic [PROB_WIDTH-1:0]   table_cum;
  logic                    sym_valid;
  logic                    sym_ready;
  logic [SYMBOL_WIDTH-1:0] sym_in;
  logic                    sym_last;
  logic                    byte_valid;
  logic                    byte_ready;
  logic [7:0]              byte_out;
  logic                    byte_last;
  logic [STATE_WIDTH-1:0]  state_out;
  logic                    busy;
  logic                    error;

  modport master (
    output table_write, table_addr,
    output table_freq, table_cum,
    output sym_valid, sym_in, sym_last,
    output byte_ready,
    input  sym_ready, byte_valid,
    input  byte_out, byte_last,
    input  state_out, busy, error
  );

  modport slave (
    input  table_write, table_addr,
    input  table_freq, table_cum,
    input  sym_valid, sym_in, sym_last,
    input  byte_ready,
    output sym_ready, byte_valid,
    output byte_out, byte_last,
    output state_out, busy, error
  );
endinterface

// File: rtl/ans_symbol_encoder.sv
// ans_symbol_encoder: rANS encoder, 4-bit symbols to bytes via freq/cum table.
// Ports: clk, rst (async, active-low), bus (ans_symbol_encoder_if.slave).
module ans_symbol_encoder #(
  parameter int STATE_WIDTH  = 32,
  parameter int PROB_WIDTH   = 8,
  parameter int SYMBOL_WIDTH = 4,
  parameter int NUM_SYMBOLS  = 16,
  parameter int SCALE_BITS   = 8
) (
  input logic clk,
  input logic rst,
  ans_symbol_encoder_if.slave bus
);
  localparam int CW = $clog2(STATE_WIDTH);
  localparam int NB = STATE_WIDTH / 8;
  localparam int XSH = STATE_WIDTH - 1 - SCALE_BITS;
  localparam logic [CW-1:0] DIV_LAST = CW'(STATE_WIDTH - 1);
  localparam logic [CW-1:0] FL_LAST = CW'(NB - 1);
  localparam logic [STATE_WIDTH-1:0] L_INIT =
    STATE_WIDTH'(1) << (STATE_WIDTH - 9);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RENORM, DIV, UPDATE, FLUSH
  } state_t;

  state_t state, state_nx;

  logic [PROB_WIDTH-1:0] freq_tab [NUM_SYMBOLS];
  logic [PROB_WIDTH-1:0] cum_tab  [NUM_SYMBOLS];

  logic [STATE_WIDTH-1:0]  x, q, x_max;
  logic [PROB_WIDTH-1:0]   freq_q, cum_q, rem, rem_nx;
  logic [SYMBOL_WIDTH-1:0] sym_q;
  logic                    last_q;
  logic [CW-1:0]           cnt;
  logic [PROB_WIDTH:0]     trial;
  logic                    fit, need_byte, tab_zero;

  assign x_max = STATE_WIDTH'(freq_q) << XSH;
  assign need_byte = x >= x_max;
  assign tab_zero = freq_tab[sym_q] == '0;

  // restoring divide step: remainder stays below freq,
  // so the 8-bit wraparound subtract is exact
  assign trial = {rem, q[STATE_WIDTH-1]};
  assign fit = trial >= {1'b0, freq_q};
  assign rem_nx = fit ? trial[PROB_WIDTH-1:0] - freq_q
                      : trial[PROB_WIDTH-1:0];

  assign bus.state_out = x;

  always_ff @(posedge clk) begin
    if (bus.table_write) begin
      freq_tab[bus.table_addr] <= bus.table_freq;
      cum_tab[bus.table_addr]  <= bus.table_cum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.sym_valid) state_nx = LOOKUP;
      LOOKUP:
        state_nx = tab_zero ? IDLE : RENORM;
      RENORM:
        if (!need_byte) state_nx = DIV;
      DIV:
        if (cnt == DIV_LAST) state_nx = UPDATE;
      UPDATE:
        state_nx = last_q ? FLUSH : IDLE;
      FLUSH:
        if (bus.byte_ready && cnt == FL_LAST)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.sym_ready  = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_out   = 8'h00;
    bus.byte_last  = 1'b0;
    bus.busy       = 1'b1;
    bus.error      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.sym_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      LOOKUP:
        bus.error = tab_zero;
      RENORM:
        if (need_byte) begin
          bus.byte_valid = 1'b1;
          bus.byte_out   = x[7:0];
        end
      FLUSH: begin
        bus.byte_valid = 1'b1;
        bus.byte_out   = x[7:0];
        bus.byte_last  = cnt == FL_LAST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x      <= L_INIT;
      q      <= '0;
      rem    <= '0;
      cnt    <= '0;
      sym_q  <= '0;
      last_q <= 1'b0;
      freq_q <= '0;
      cum_q  <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.sym_valid) begin
            sym_q  <= bus.sym_in;
            last_q <= bus.sym_last;
          end
        LOOKUP: begin
          freq_q <= freq_tab[sym_q];
          cum_q  <= cum_tab[sym_q];
        end
        RENORM:
          if (need_byte) begin
            if (bus.byte_ready) x <= x >> 8;
          end else begin
            q   <= x;
            rem <= '0;
            cnt <= '0;
          end
        DIV: begin
          q   <= {q[STATE_WIDTH-2:0], fit};
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
        end
        UPDATE: begin
          x <= (q << SCALE_BITS)
             + STATE_WIDTH'(rem)
             + STATE_WIDTH'(cum_q);
          cnt <= '0;
        end
        FLUSH:
          if (bus.byte_ready) begin
            cnt <= cnt + CW'(1);
            x   <= (cnt == FL_LAST) ? L_INIT : x >> 8;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ans_symbol_encoder.sv
// tb_ans_symbol_encoder: scoreboard bench for the rANS symbol encoder.
// Directed table scenarios plus random tables/symbols vs arithmetic model.
module tb_ans_symbol_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;

  ans_symbol_encoder_if bus();

  ans_symbol_encoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  localparam longint LV = 64'h80_0000;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } byte_t;

  typedef struct {
    longint x;
    int     err;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int tfreq[16];
  int tcum[16];
  longint mx = LV;
  int ready_mode = 0;
  byte_t bq[$];
  exp_t sq[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // reference: plain rANS arithmetic on a 64-bit integer
  task automatic model(input int s, input bit last,
                       output int lat);
    longint f;
    f = longint'(tfreq[s]);
    if (f == 0) begin
      sq.push_back('{x: mx, err: 1});
      lat = 2;
      return;
    end
    lat = 36;
    while (mx >= (f << 23)) begin
      bq.push_back('{b: 8'(mx % 256), last: 1'b0});
      mx = mx / 256;
      lat++;
    end
    mx = (mx / f) * 256 + (mx % f) + longint'(tcum[s]);
    if (last) begin
      for (int i = 0; i < 4; i++)
        bq.push_back('{b: 8'((mx >> (8 * i)) % 256),
                       last: (i == 3)});
      mx = LV;
      lat += 4;
    end
    sq.push_back('{x: mx, err: 0});
  endtask

  task automatic wr(input int a, input int f, input int c);
    bus.table_write = 1'b1;
    bus.table_addr  = 4'(a);
    bus.table_freq  = 8'(f);
    bus.table_cum   = 8'(c);
    @(posedge clk); #1;
    bus.table_write = 1'b0;
    tfreq[a] = f;
    tcum[a]  = c;
  endtask

  task automatic send(input int s, input bit last,
                      input bit chk_lat, input bit wait_done);
    int n;
    int lat;
    int exp_lat;
    n = 0;
    while (!bus.sym_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      chk("sym_ready_timeout", 64'(n), 64'(0));
      return;
    end
    model(s, last, exp_lat);
    bus.sym_valid = 1'b1;
    bus.sym_in    = 4'(s);
    bus.sym_last  = last;
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
    bus.sym_last  = 1'b0;
    if (!wait_done) return;
    lat = 1;
    while (!bus.sym_ready && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 3000)
      chk("done_timeout", 64'(lat), 64'(exp_lat));
    else if (chk_lat)
      chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_reset();
    chk("rst_state_out", bus.state_out, LV);
    chk("rst_sym_ready", bus.sym_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_byte_valid", bus.byte_valid, 0);
    chk("rst_byte_out", bus.byte_out, 0);
    chk("rst_byte_last", bus.byte_last, 0);
    chk("rst_error", bus.error, 0);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    check_reset();
    bq.delete();
    sq.delete();
    mx = LV;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic rand_table();
    logic [15:0] m;
    int idx;
    int c;
    m = 16'($urandom) | 16'h0003;
    for (int i = 0; i < 16; i++) tfreq[i] = 0;
    for (int u = 0; u < 256; u++) begin
      do idx = $urandom_range(0, 15);
      while (!m[idx] || tfreq[idx] == 255);
      tfreq[idx]++;
    end
    c = 0;
    for (int i = 0; i < 16; i++) begin
      wr(i, tfreq[i], c % 256);
      c += tfreq[i];
    end
  endtask

  // byte_ready source: always, random, or 5-cycle stall per byte
  initial begin
    int sc;
    sc = 0;
    bus.byte_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.byte_ready = 1'b1;
        1: bus.byte_ready = ($urandom_range(0, 3) != 0);
        default:
          if (!bus.byte_valid) begin
            bus.byte_ready = 1'b0;
            sc = 0;
          end else if (sc < 5) begin
            bus.byte_ready = 1'b0;
            sc++;
          end else begin
            bus.byte_ready = 1'b1;
            sc = 0;
          end
      endcase
    end
  end

  // monitor: pops expected bytes and per-symbol results
  initial begin
    bit pb;
    bit ps;
    logic [7:0] hb;
    logic hl;
    int ec;
    byte_t eb;
    exp_t es;
    pb = 0;
    ps = 0;
    ec = 0;
    hb = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pb = 0;
        ps = 0;
        ec = 0;
      end else begin
        if (bus.error) ec++;
        chk("ready_vs_busy", bus.sym_ready, !bus.busy);
        if (ps) begin
          chk("valid_held", bus.byte_valid, 1);
          if (bus.byte_valid) begin
            chk("byte_stable", bus.byte_out, hb);
            chk("last_stable", bus.byte_last, hl);
          end
        end
        if (bus.byte_valid && bus.byte_ready) begin
          if (bq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte_extra actual=%0h required=none",
                     bus.byte_out);
          end else begin
            eb = bq.pop_front();
            chk("byte_out", bus.byte_out, eb.b);
            chk("byte_last", bus.byte_last, eb.last);
          end
        end
        ps = bus.byte_valid && !bus.byte_ready;
        hb = bus.byte_out;
        hl = bus.byte_last;
        if (pb && !bus.busy) begin
          if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sym_extra actual=%0h required=none",
                     bus.state_out);
          end else begin
            es = sq.pop_front();
            chk("state_out", bus.state_out, es.x);
            chk("error_pulses", 64'(ec), 64'(es.err));
          end
          ec = 0;
        end
        pb = bus.busy;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.table_write = 1'b0;
    bus.table_addr  = '0;
    bus.table_freq  = '0;
    bus.table_cum   = '0;
    bus.sym_valid   = 1'b0;
    bus.sym_in      = '0;
    bus.sym_last    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b1;
    @(posedge clk); #1;

    // common table
    wr(0, 128, 0);
    wr(1, 64, 128);
    wr(2, 64, 192);
    for (int i = 3; i < 16; i++) wr(i, 0, 0);

    // basic encode, then flush
    send(1, 0, 1, 1);
    chk("basic_x", bus.state_out, 64'h0200_0080);
    send(2, 1, 1, 1);
    chk("flush_x", bus.state_out, LV);

    // renormalisation
    reset_pulse();
    wr(3, 1, 255);
    send(3, 0, 1, 1);
    chk("renorm_x", bus.state_out, 64'h0080_00FF);

    // backpressure on the flush scenario
    reset_pulse();
    ready_mode = 2;
    send(1, 0, 0, 1);
    send(2, 1, 0, 1);
    ready_mode = 0;
    @(posedge clk); #1;
    chk("bp_x", bus.state_out, LV);

    // zero frequency, sym_last must not flush
    wr(5, 0, 0);
    send(5, 1, 1, 1);
    chk("zero_x", bus.state_out, LV);

    // reset during DIV
    send(1, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("in_div_busy", bus.busy, 1);
    reset_pulse();
    send(1, 0, 1, 1);
    chk("post_rst_x", bus.state_out, 64'h0200_0080);

    // random tables and symbols
    ready_mode = 1;
    for (int t = 0; t < 2; t++) begin
      rand_table();
      for (int k = 0; k < 150; k++)
        send($urandom_range(0, 15),
             ($urandom_range(0, 7) == 0), 0, 1);
    end
    send(0, 1, 0, 1);
    ready_mode = 0;

    repeat (3) @(negedge clk);
    chk("bytes_drained", 64'(bq.size()), 0);
    chk("syms_drained", 64'(sq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ans_symbol_encoder.md
# ans_symbol_encoder

rANS symbol encoder: the transmit side of the ANS path. It converts a stream of 4-bit symbols into a byte stream that the ANS symbol decoder consumes, using a loadable per-symbol frequency/cumulative table. It sits between the camera-encoder symbol source and the bitstream packer. Bytes leave in encode order, and the packer reverses each flushed block before the decoder reads it.

## Interface
Parameters:
- STATE_WIDTH, 32, coder state width
- PROB_WIDTH, 8, frequency and cumulative field width
- SYMBOL_WIDTH, 4, symbol width
- NUM_SYMBOLS, 16, table entries
- SCALE_BITS, 8, frequency total is 2^SCALE_BITS

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- table_write  in  1  write strobe for the frequency table
- table_addr  in  SYMBOL_WIDTH  table entry index
- table_freq  in  PROB_WIDTH  symbol frequency, 1..255
- table_cum  in  PROB_WIDTH  cumulative frequency, 0..255
- sym_valid  in  1  symbol offered
- sym_ready  out  1  encoder accepts a symbol
- sym_in  in  SYMBOL_WIDTH  symbol
- sym_last  in  1  flush the state after this symbol
- byte_valid  out  1  output byte valid
- byte_ready  in  1  downstream accepts the byte
- byte_out  out  8  output byte
- byte_last  out  1  final byte of a flushed block
- state_out  out  STATE_WIDTH  current coder state x
- busy  out  1  FSM not in IDLE
- error  out  1  one-cycle pulse: symbol with freq = 0 dropped

## Operation
- Constants:
  - L = 2^(STATE_WIDTH-9) = 0x0080_0000.
  - x_max(s) = freq(s) << (STATE_WIDTH-1-SCALE_BITS), which is freq << 23.
- Table: registered arrays, written on clk when table_write = 1, at any time. Table contents are not reset.
- FSM states: IDLE, LOOKUP, RENORM, DIV, UPDATE, FLUSH.
- IDLE:
  - sym_ready = 1.
  - On sym_valid & sym_ready, capture sym_in and sym_last, then go to LOOKUP.
- LOOKUP:
  - Latch freq and cum of the symbol. A table write to the same address in this cycle is not seen; the old value is used.
  - If freq = 0: pulse error, leave x unchanged, go to IDLE.
  - Otherwise go to RENORM.
- RENORM:
  - If x >= x_max: assert byte_valid with byte_out = x[7:0]. On byte_ready, x <= x >> 8 and re-check next cycle.
  - Else go to DIV.
- DIV:
  - 32-iteration restoring divide, x / freq, one quotient bit per cycle.
  - Produces q (32 bit) and r (8 bit).
- UPDATE:
  - x <= (q << SCALE_BITS) + r + cum.
  - If the captured sym_last = 1, go to FLUSH; else go to IDLE.
- FLUSH:
  - Emit x as 4 bytes, LSB first. Each byte advances on byte_valid & byte_ready.
  - byte_last = 1 on the 4th byte.
  - After the 4th handshake, x <= L and go to IDLE.
- Invariant: x is always in [L, 2^32) at IDLE, so UPDATE never overflows for a valid table (Σfreq = 256).
- Arithmetic: the compare x >= x_max is 32-bit unsigned with freq zero-extended.

## Timing
- Reset values:
  - x = L, so state_out = 0x0080_0000.
  - FSM = IDLE, so sym_ready = 1 and busy = 0.
  - byte_valid = 0, byte_out = 0, byte_last = 0, error = 0.
- Reset mid-operation (any state) aborts the symbol immediately and restores all reset values. Partial bytes are lost.
- Symbol latency with no renormalisation: handshake in cycle N, LOOKUP N+1, RENORM N+2, DIV N+3..N+34, UPDATE N+35, sym_ready = 1 again at N+36.
- Each renormalisation byte adds 1 cycle plus any byte_ready stall cycles.
- FLUSH adds at least 4 cycles.
- Output handshake:
  - byte_out and byte_last stay stable while byte_valid = 1 and byte_ready = 0.
  - byte_valid never drops without a handshake.
  - byte_valid may rise without waiting for byte_ready.
- Error cases:
  - error is asserted in the LOOKUP cycle only.
  - A sym_last on an errored symbol does not flush.
- sym_ready = 0 in every state except IDLE.

## Test plan
Common table for scenarios 1, 2 and 4: sym0 freq 128 cum 0, sym1 freq 64 cum 128, sym2 freq 64 cum 192.
- **Basic encode:** encode sym1 from reset -> no bytes; state_out = 0x0200_0080 at the cycle sym_ready returns (N+36).
- **Flush:** then encode sym2 with sym_last = 1 -> x = 0x0800_02C0; bytes C0, 02, 00, 08 with byte_last only on 08; state_out returns to 0x0080_0000.
- **Renormalisation:** after reset, set sym3 freq 1 cum 255 and encode sym3 -> one byte 0x00 emitted, then x = 0x0080_00FF.
- **Backpressure:** repeat the flush scenario with byte_ready held low 5 cycles on each byte -> byte_out stable, bytes and order unchanged, no duplicates.
- **Zero frequency:** sym5 with freq 0 -> error is a single pulse in the LOOKUP cycle, no byte, state_out unchanged, sym_ready back 2 cycles after the handshake.
- **Reset mid-operation:** assert rst during DIV -> all outputs at reset values in the same cycle; the next encode of sym1 gives 0x0200_0080.
